fifo_axi_wburst: RTL

FIFO_AXI_WBURST -- requirements
Module: fifo_axi_wburst

---
 rtl/ddr_axi_pkg.sv | 32 +++
 rtl/axi_w_out_reg.sv | 46 ++++
 rtl/fifo_axi_wburst.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ddr_axi_pkg.sv
// ---------------------------------------------------------------------------
// Module   : ddr_axi_pkg
// Brief    : Shared types and AXI encodings for the FIFO-to-AXI write path.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ddr_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI size field: log2 of bytes per beat for a power-of-two data width.
    function automatic logic [2:0] axi_size_log2(input int unsigned data_width);
        logic [2:0] w_size;
        w_size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd8 << i) == data_width) w_size = i[2:0];
        end
        return w_size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_w_out_reg.sv
// ---------------------------------------------------------------------------
// Module   : axi_w_out_reg
// Brief    : One-entry valid/ready output register holding wdata and wlast.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module axi_w_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_load_last,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_load_data;
            r_last  <= i_load_last;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fifo_axi_wburst.sv
// ---------------------------------------------------------------------------
// Module   : fifo_axi_wburst
// Brief    : Drains a show-ahead FIFO into fixed-length AXI INCR write bursts.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_axi_wburst
    import ddr_axi_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    BURST_LEN    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    WINDOW_BYTES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_empty,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    busy,
    output logic [31:0]             burst_cnt,
    output logic                    err
);

    localparam logic [ADDR_WIDTH:0] c_burst_bytes = (ADDR_WIDTH+1)'(BURST_LEN * (DATA_WIDTH / 8));
    localparam logic [ADDR_WIDTH:0] c_window_end  = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(WINDOW_BYTES);
    localparam logic [8:0]          c_burst_len   = 9'(BURST_LEN);
    localparam logic [8:0]          c_last_beat   = 9'(BURST_LEN - 1);

    wb_state_t             r_state;
    wb_state_t             w_state_next;
    logic [8:0]            r_beat_cnt;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH:0]   w_addr_sum;
    logic [31:0]           r_burst_cnt;
    logic                  r_err;
    logic                  w_load;
    logic                  w_w_done;
    logic                  w_b_done;

    // Pop only when the output register can take the word this cycle.
    assign w_load   = !rst && (r_state == ST_W) && !fifo_empty &&
                      (r_beat_cnt < c_burst_len) && (!wvalid || wready);
    assign w_w_done = (r_state == ST_W) && wvalid && wready && wlast;
    assign w_b_done = (r_state == ST_B) && bvalid;
    assign w_addr_sum = {1'b0, r_awaddr} + c_burst_bytes;

    always_comb begin
        w_state_next = r_state;
        awvalid      = 1'b0;
        bready       = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (en && !fifo_empty) w_state_next = ST_AW;
            end
            ST_AW: begin
                awvalid = 1'b1;
                if (awready) w_state_next = ST_W;
            end
            ST_W: begin
                if (w_w_done) w_state_next = ST_B;
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_awaddr    <= BASE_ADDR;
            r_burst_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_AW) r_beat_cnt <= '0;
            else if (w_load)      r_beat_cnt <= r_beat_cnt + 9'd1;
            if (w_b_done) begin
                r_burst_cnt <= r_burst_cnt + 32'd1;
                r_awaddr    <= (w_addr_sum >= c_window_end) ? BASE_ADDR : w_addr_sum[ADDR_WIDTH-1:0];
                if (bresp != AXI_RESP_OKAY) r_err <= 1'b1;
            end
        end
    end

    axi_w_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_w_out (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_data (fifo_rd_data),
        .i_load_last (r_beat_cnt == c_last_beat),
        .i_ready     (wready),
        .o_data      (wdata),
        .o_last      (wlast),
        .o_valid     (wvalid)
    );

    assign fifo_rd_en = w_load;
    assign awaddr     = r_awaddr;
    assign awlen      = 8'(BURST_LEN - 1);
    assign awsize     = axi_size_log2(DATA_WIDTH);
    assign awburst    = AXI_BURST_INCR;
    assign wstrb      = '1;
    assign burst_cnt  = r_burst_cnt;
    assign err        = r_err;

endmodule

`default_nettype wire
